// File: rtl/scaler_matrix_ram.sv
// K-line circular line buffer that feeds a K x K sliding pixel window to a scaler.
// Raster pixels fill the lines; each accepted column read shifts one column into the window.
module scaler_matrix_ram #(
  parameter int PIXEL_BITWIDTH = 8,
  parameter int IMG_H_MAX      = 3840,
  parameter int IMG_V_MAX      = 2160,
  parameter int IMG_H_BITWIDTH = $clog2(IMG_H_MAX),
  parameter int IMG_V_BITWIDTH = $clog2(IMG_V_MAX),
  parameter int KERNEL_MAX     = 4
) (
  input  logic                                           core_clk,
  input  logic                                           core_rst,
  input  logic [IMG_H_BITWIDTH-1:0]                      core_arg_img_src_h,
  input  logic [IMG_V_BITWIDTH-1:0]                      core_arg_img_src_v,
  input  logic                                           core_start,
  input  logic                                           s_axis_pixel_valid,
  output logic                                           s_axis_pixel_ready,
  input  logic [PIXEL_BITWIDTH-1:0]                      s_axis_pixel_data,
  input  logic                                           s_axis_connect_ready,
  output logic                                           s_axis_connect_valid,
  input  logic                                           matrix_ram_read_stride,
  input  logic                                           matrix_ram_read_repeat,
  input  logic                                           matrix_ram_read_en,
  input  logic                                           matrix_ram_read_done,
  output logic                                           matrix_ram_read_rsp_en,
  output logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0] matrix_ram_read_rsp_pixel
);

  localparam int K  = KERNEL_MAX;
  localparam int KB = (K > 1) ? $clog2(K) : 1;
  localparam int VW = IMG_V_BITWIDTH + 1;
  localparam logic [IMG_H_BITWIDTH-1:0] H_ONE = 1;
  localparam logic [IMG_V_BITWIDTH-1:0] V_ONE = 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                      r_state;
  logic [IMG_H_BITWIDTH-1:0]   r_w;
  logic [IMG_H_BITWIDTH-1:0]   r_wr_col;
  logic [IMG_H_BITWIDTH-1:0]   r_col;
  logic [IMG_V_BITWIDTH-1:0]   r_h;
  logic [IMG_V_BITWIDTH-1:0]   r_wr_line;
  logic [IMG_V_BITWIDTH-1:0]   r_top;
  logic                        r_fill;

  logic                        r_p1_valid;
  logic                        r_p1_fill;
  logic [KB-1:0]               r_p1_sel [K];
  logic                        r_rsp_en;
  logic [PIXEL_BITWIDTH-1:0]   r_win [K][K];

  logic [VW-1:0]               w_wr_line_x;
  logic [VW-1:0]               w_h_x;
  logic [VW-1:0]               w_h_last;
  logic [VW-1:0]               w_top_x;
  logic [VW-1:0]               w_last_row;
  logic [VW-1:0]               w_row_line [K];
  logic [KB-1:0]               w_row_slot [K];
  logic [KB-1:0]               w_wr_slot;
  logic [PIXEL_BITWIDTH-1:0]   w_rd_q [K];
  logic [PIXEL_BITWIDTH-1:0]   w_col_vec [K];
  logic                        w_run;
  logic                        w_pix_ready;
  logic                        w_conn_valid;
  logic                        w_wr_fire;
  logic                        w_rd_fire;

  // Line indices carry one spare bit so top+K never wraps.
  assign w_wr_line_x  = {1'b0, r_wr_line};
  assign w_h_x        = {1'b0, r_h};
  assign w_h_last     = w_h_x - VW'(1);
  assign w_top_x      = {1'b0, r_top};
  assign w_last_row   = (w_top_x + VW'(K - 1) > w_h_last) ? w_h_last : w_top_x + VW'(K - 1);
  assign w_wr_slot    = r_wr_line[KB-1:0];

  assign w_run        = (r_state == ST_RUN);
  assign w_pix_ready  = w_run && (w_wr_line_x < w_h_x) && (w_wr_line_x < w_top_x + VW'(K));
  assign w_conn_valid = w_run && (w_wr_line_x > w_last_row);
  assign w_wr_fire    = s_axis_pixel_valid && w_pix_ready;
  assign w_rd_fire    = w_conn_valid && s_axis_connect_ready && matrix_ram_read_en &&
                        !matrix_ram_read_stride && !matrix_ram_read_repeat;

  assign s_axis_pixel_ready     = w_pix_ready;
  assign s_axis_connect_valid   = w_conn_valid;
  assign matrix_ram_read_rsp_en = r_rsp_en;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      w_row_line[r] = w_top_x + VW'(r);
      if (w_row_line[r] > w_h_last) w_row_line[r] = w_h_last;
      w_row_slot[r] = w_row_line[r][KB-1:0];
      w_col_vec[r]  = w_rd_q[r_p1_sel[r]];
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state   <= ST_IDLE;
      r_w       <= '0;
      r_h       <= '0;
      r_wr_col  <= '0;
      r_wr_line <= '0;
      r_top     <= '0;
      r_col     <= '0;
      r_fill    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (core_start) begin
            r_state   <= ST_RUN;
            r_w       <= core_arg_img_src_h;
            r_h       <= core_arg_img_src_v;
            r_wr_col  <= '0;
            r_wr_line <= '0;
            r_top     <= '0;
            r_col     <= '0;
            r_fill    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_wr_fire) begin
            if (r_wr_col == r_w - H_ONE) begin
              r_wr_col  <= '0;
              r_wr_line <= r_wr_line + V_ONE;
            end else begin
              r_wr_col <= r_wr_col + H_ONE;
            end
          end
          // The column counter saturates at the right edge, which replicates the last column.
          if (matrix_ram_read_stride) begin
            r_col  <= '0;
            r_fill <= 1'b1;
            if (w_top_x < w_h_last) r_top <= r_top + V_ONE;
          end else if (matrix_ram_read_repeat) begin
            r_col  <= '0;
            r_fill <= 1'b1;
          end else if (w_rd_fire) begin
            r_fill <= 1'b0;
            if (r_col < r_w - H_ONE) r_col <= r_col + H_ONE;
          end
          if (matrix_ram_read_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar s = 0; s < K; s++) begin : g_line
    logic [PIXEL_BITWIDTH-1:0] r_mem [IMG_H_MAX];
    logic [PIXEL_BITWIDTH-1:0] r_q;
    always_ff @(posedge core_clk) begin
      if (w_wr_fire && (w_wr_slot == KB'(s))) r_mem[r_wr_col] <= s_axis_pixel_data;
      if (w_rd_fire) r_q <= r_mem[r_col];
    end
    assign w_rd_q[s] = r_q;
  end

  // Second stage steers each line RAM output to its window row and shifts the window.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_p1_valid <= 1'b0;
      r_p1_fill  <= 1'b0;
      r_rsp_en   <= 1'b0;
      for (int r = 0; r < K; r++) begin
        r_p1_sel[r] <= '0;
        for (int c = 0; c < K; c++) r_win[r][c] <= '0;
      end
    end else begin
      r_p1_valid <= w_rd_fire;
      r_p1_fill  <= r_fill;
      r_rsp_en   <= r_p1_valid;
      for (int r = 0; r < K; r++) r_p1_sel[r] <= w_row_slot[r];
      if (r_p1_valid) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) r_win[r][c] <= r_p1_fill ? w_col_vec[r] : r_win[r][c+1];
          r_win[r][K-1] <= w_col_vec[r];
        end
      end else if ((r_state == ST_IDLE) && core_start) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) r_win[r][c] <= '0;
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_pack_row
    for (genvar c = 0; c < K; c++) begin : g_pack_col
      assign matrix_ram_read_rsp_pixel[(r*K+c)*PIXEL_BITWIDTH +: PIXEL_BITWIDTH] = r_win[r][c];
    end
  end

endmodule

// File: tb/tb_scaler_matrix_ram.sv
// Self-checking bench for scaler_matrix_ram: a frame-level model predicts ready/valid
// and every window response; a few literal window values pin the model itself.
module tb_scaler_matrix_ram;

  localparam int P    = 8;
  localparam int K    = 4;
  localparam int HB   = 12;
  localparam int VB   = 12;
  localparam int WIDE = P * K * K;

  logic            coreClk;
  logic            coreRst;
  logic [HB-1:0]   imgH;
  logic [VB-1:0]   imgV;
  logic            coreStart;
  logic            pixValid;
  logic            pixReady;
  logic [P-1:0]    pixData;
  logic            connReady;
  logic            connValid;
  logic            rdStride;
  logic            rdRepeat;
  logic            rdEn;
  logic            rdDone;
  logic            rspEn;
  logic [WIDE-1:0] rspPixel;

  scaler_matrix_ram #(
    .PIXEL_BITWIDTH(P),
    .IMG_H_MAX(3840),
    .IMG_V_MAX(2160),
    .IMG_H_BITWIDTH(HB),
    .IMG_V_BITWIDTH(VB),
    .KERNEL_MAX(K)
  ) dut (
    .core_clk(coreClk),
    .core_rst(coreRst),
    .core_arg_img_src_h(imgH),
    .core_arg_img_src_v(imgV),
    .core_start(coreStart),
    .s_axis_pixel_valid(pixValid),
    .s_axis_pixel_ready(pixReady),
    .s_axis_pixel_data(pixData),
    .s_axis_connect_ready(connReady),
    .s_axis_connect_valid(connValid),
    .matrix_ram_read_stride(rdStride),
    .matrix_ram_read_repeat(rdRepeat),
    .matrix_ram_read_en(rdEn),
    .matrix_ram_read_done(rdDone),
    .matrix_ram_read_rsp_en(rspEn),
    .matrix_ram_read_rsp_pixel(rspPixel)
  );

  // Frame-level model state
  int  frame [16][16];
  bit  mRun;
  int  mW, mH, mWrLine, mWrCol, mTop, mCol;
  bit  mFill;
  int  mWin [K][K];
  int  argW, argH;

  typedef struct {
    int              due;
    logic [WIDE-1:0] pix;
  } rsp_t;
  rsp_t rspQ[$];

  int              ncyc;
  int              clearDue;
  bit              checkEn;
  logic [WIDE-1:0] lastPix;
  logic [WIDE-1:0] lastDutPix;
  int              nChecks;
  int              nFails;

  initial begin
    coreClk = 1'b0;
    forever #5 coreClk = ~coreClk;
  end

  always @(posedge coreClk) ncyc <= ncyc + 1;

  task automatic checkOutput(input string name, input logic [WIDE-1:0] act, input logic [WIDE-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic logic [WIDE-1:0] packWin();
    logic [WIDE-1:0] v;
    v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) v[(r*K+c)*P +: P] = P'(mWin[r][c]);
    return v;
  endfunction

  function automatic logic [31:0] rowOf(input logic [WIDE-1:0] v, input int r);
    logic [31:0] o;
    for (int c = 0; c < K; c++) o[(K-1-c)*8 +: 8] = v[(r*K+c)*P +: P];
    return o;
  endfunction

  function automatic logic [31:0] colOf(input logic [WIDE-1:0] v, input int c);
    logic [31:0] o;
    for (int r = 0; r < K; r++) o[(K-1-r)*8 +: 8] = v[(r*K+c)*P +: P];
    return o;
  endfunction

  // Response checker: every cycle either a due window or a held, silent output.
  always @(negedge coreClk) begin
    if (checkEn) begin
      if (clearDue == ncyc) lastPix = '0;
      if (rspQ.size() > 0 && rspQ[0].due == ncyc) begin
        checkOutput("rsp_en", WIDE'(rspEn), WIDE'(1));
        checkOutput("rsp_pixel", rspPixel, rspQ[0].pix);
        lastPix    = rspQ[0].pix;
        lastDutPix = rspPixel;
        void'(rspQ.pop_front());
      end else begin
        checkOutput("rsp_en_idle", WIDE'(rspEn), WIDE'(0));
        checkOutput("rsp_hold", rspPixel, lastPix);
      end
    end
  end

  // One clock cycle: drive inputs, check ready/valid, advance the model, step to next negedge.
  task automatic applyStimulus(input bit pv, input int pd, input bit cr, input bit ren,
                               input bit stride, input bit rep, input bit done, input bit start);
    int  line, cc;
    int  v [K];
    bit  expReady, expValid, rdFire;
    int  lastRow;
    pixValid  = pv;
    pixData   = P'(pd);
    connReady = cr;
    rdEn      = ren;
    rdStride  = stride;
    rdRepeat  = rep;
    rdDone    = done;
    coreStart = start;
    imgH      = HB'(argW);
    imgV      = VB'(argH);
    #1;
    lastRow  = (mTop + K - 1 < mH - 1) ? mTop + K - 1 : mH - 1;
    expReady = mRun && (mWrLine < mH) && (mWrLine - mTop < K);
    expValid = mRun && (mWrLine > lastRow);
    checkOutput("pixel_ready", WIDE'(pixReady), WIDE'(expReady));
    checkOutput("connect_valid", WIDE'(connValid), WIDE'(expValid));
    if (!coreRst) begin
      if (!mRun) begin
        if (start) begin
          mRun = 1; mW = argW; mH = argH;
          mWrLine = 0; mWrCol = 0; mTop = 0; mCol = 0; mFill = 1;
          for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) mWin[r][c] = 0;
          clearDue = ncyc + 1;
        end
      end else begin
        rdFire = ren && expValid && cr && !stride && !rep;
        if (pv && expReady) begin
          frame[mWrLine][mWrCol] = pd & 8'hff;
          mWrCol++;
          if (mWrCol == mW) begin mWrCol = 0; mWrLine++; end
        end
        if (stride) begin
          mCol = 0; mFill = 1;
          mTop = (mTop + 1 < mH - 1) ? mTop + 1 : mH - 1;
        end else if (rep) begin
          mCol = 0; mFill = 1;
        end else if (rdFire) begin
          cc = (mCol < mW - 1) ? mCol : mW - 1;
          for (int r = 0; r < K; r++) begin
            line = (mTop + r < mH - 1) ? mTop + r : mH - 1;
            v[r] = frame[line][cc];
          end
          for (int r = 0; r < K; r++) begin
            if (mFill) for (int c = 0; c < K; c++) mWin[r][c] = v[r];
            else begin
              for (int c = 0; c < K - 1; c++) mWin[r][c] = mWin[r][c+1];
              mWin[r][K-1] = v[r];
            end
          end
          rspQ.push_back('{due: ncyc + 2, pix: packWin()});
          mCol++; mFill = 0;
        end
        if (done) mRun = 0;
      end
    end
    @(posedge coreClk);
    @(negedge coreClk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writeRaster(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 16 * mWrLine + mWrCol, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic readCols(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic startFrame(input int w, input int h);
    argW = w; argH = h;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, nChecks=%0d", nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0; nFails = 0; ncyc = 0; clearDue = -1; checkEn = 0;
    mRun = 0; mW = 0; mH = 0; mWrLine = 0; mWrCol = 0; mTop = 0; mCol = 0; mFill = 0;
    argW = 8; argH = 6; lastPix = '0; lastDutPix = '0;
    coreRst = 1'b1;
    pixValid = 0; pixData = '0; connReady = 0; rdEn = 0; rdStride = 0; rdRepeat = 0;
    rdDone = 0; coreStart = 0; imgH = '0; imgV = '0;
    @(negedge coreClk);
    @(negedge coreClk);
    checkOutput("reset_ready", WIDE'(pixReady), WIDE'(0));
    checkOutput("reset_valid", WIDE'(connValid), WIDE'(0));
    checkOutput("reset_rsp_en", WIDE'(rspEn), WIDE'(0));
    checkOutput("reset_rsp_pixel", rspPixel, WIDE'(0));
    coreRst = 1'b0;
    checkEn = 1;

    $display("[TB] directed frame W=8 H=6");
    startFrame(8, 6);
    writeRaster(32);
    checkOutput("valid_after_4_lines", WIDE'(connValid), WIDE'(1));
    checkOutput("ready_stalled_top0", WIDE'(pixReady), WIDE'(0));
    readCols(3);
    idle(2);
    checkOutput("third_rsp_row0", WIDE'(rowOf(lastDutPix, 0)), WIDE'(32'h00000102));
    readCols(10);
    idle(2);
    checkOutput("right_edge_row0", WIDE'(rowOf(lastDutPix, 0)), WIDE'(32'h07070707));

    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("ready_after_stride", WIDE'(pixReady), WIDE'(1));
    writeRaster(8);
    readCols(5);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
    readCols(5);
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 0);
    checkOutput("stride_beats_repeat", WIDE'(pixReady), WIDE'(1));
    writeRaster(8);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("bottom_valid", WIDE'(connValid), WIDE'(1));
    readCols(1);
    idle(2);
    checkOutput("bottom_clamp_col0", WIDE'(colOf(lastDutPix, 0)), WIDE'(32'h40505050));
    readCols(1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
    idle(4);

    $display("[TB] reset during pending response");
    startFrame(4, 2);
    writeRaster(8);
    readCols(1);
    #2;
    coreRst = 1'b1;
    rspQ.delete();
    lastPix = '0;
    mRun = 0;
    #1;
    checkOutput("abort_ready", WIDE'(pixReady), WIDE'(0));
    checkOutput("abort_valid", WIDE'(connValid), WIDE'(0));
    checkOutput("abort_rsp_pixel", rspPixel, WIDE'(0));
    @(negedge coreClk);
    idle(2);
    coreRst = 1'b0;
    idle(2);

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      startFrame(int'($urandom_range(1, 12)), int'($urandom_range(1, 9)));
      for (int i = 0; i < 250; i++) begin
        applyStimulus(($urandom % 4) != 0, int'($urandom_range(0, 255)), ($urandom % 4) != 0,
                      ($urandom % 2) != 0, ($urandom % 12) == 0, ($urandom % 16) == 0,
                      0, ($urandom % 32) == 0);
      end
      applyStimulus(0, 0, 1, 1, 0, 0, 1, 0);
      idle(4);
    end

    checkOutput("queue_drained", WIDE'(rspQ.size()), WIDE'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
